run_ctrl: RTL and testbench

CPU run-control state machine in the user-interface path, directly downstream of the key debouncers. It consumes the debounced level outputs of the STEP and RUN keys and produces a glitch-free clock-enable for the CPU core. Supported actions: single-step bursts, free run/pause, halt tracking, and a long-press soft reset.

---
 rtl/ui_pkg.sv | 19 +
 rtl/key_edge.sv | 24 ++
 rtl/run_ctrl.sv | 127 ++++++++++++
 tb/tb_run_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ui_pkg.sv
// Shared definitions for the user-interface run-control path.
// Mode encodings double as the FSM state encoding so o_mode is the state register.
package ui_pkg;

    localparam int UI_HOLD_W = 24;

    localparam logic [1:0] MODE_IDLE = 2'b00;
    localparam logic [1:0] MODE_STEP = 2'b01;
    localparam logic [1:0] MODE_RUN  = 2'b10;
    localparam logic [1:0] MODE_HALT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = MODE_IDLE,
        ST_STEP = MODE_STEP,
        ST_RUN  = MODE_RUN,
        ST_HALT = MODE_HALT
    } state_t;

endpackage

// File: rtl/key_edge.sv
// Press/release pulse generator for one debounced key level.
// The previous-value register resets to 0, so a key held through reset reads as a fresh press.
module key_edge (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_key,
    output logic o_press,
    output logic o_release
);

    logic r_prev;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= i_key;
        end
    end

    assign o_press   = i_key & ~r_prev;
    assign o_release = ~i_key & r_prev;

endmodule

// File: rtl/run_ctrl.sv
// CPU run-control FSM: single-step bursts, run/pause, halt tracking and RUN long-press soft reset.
// The CPU clock-enable is decoded from the state register only, so it cannot glitch on key inputs.
module run_ctrl
    import ui_pkg::*;
#(
    parameter logic [UI_HOLD_W-1:0] LONG_CNT = 24'd10_000_000,
    parameter int                   STEP_LEN = 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_key_step,
    input  logic       i_key_run,
    input  logic       i_cpu_halt,
    output logic       o_cpu_en,
    output logic [1:0] o_mode,
    output logic       o_soft_rst
);

    localparam logic [7:0] STEP_LOAD = 8'(STEP_LEN - 1);

    logic                 w_step_press;
    logic                 w_step_rel_unused;
    logic                 w_run_press_unused;
    logic                 w_run_rel;
    logic                 w_run_go;
    logic                 w_soft_fire;

    state_t               r_state;
    state_t               w_state_next;
    logic [7:0]           r_step_cnt;
    logic [7:0]           w_step_cnt_next;
    logic [UI_HOLD_W-1:0] r_hold_cnt;
    logic                 r_run_consumed;
    logic                 r_soft_rst;

    key_edge u_step_edge (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_key     (i_key_step),
        .o_press   (w_step_press),
        .o_release (w_step_rel_unused)
    );

    key_edge u_run_edge (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_key     (i_key_run),
        .o_press   (w_run_press_unused),
        .o_release (w_run_rel)
    );

    // The release that ends a long press belongs to the soft reset, not to run/pause.
    assign w_run_go    = w_run_rel & ~r_run_consumed;
    assign w_soft_fire = i_key_run & (r_hold_cnt == LONG_CNT - 1'b1);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_hold_cnt     <= '0;
            r_run_consumed <= 1'b0;
            r_soft_rst     <= 1'b0;
        end else begin
            if (!i_key_run) begin
                r_hold_cnt <= '0;
            end else if (r_hold_cnt != LONG_CNT) begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
            end
            if (w_soft_fire) begin
                r_run_consumed <= 1'b1;
            end else if (w_run_rel) begin
                r_run_consumed <= 1'b0;
            end
            r_soft_rst <= w_soft_fire;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_step_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_step_cnt <= w_step_cnt_next;
        end
    end

    // Soft reset outranks halt, which outranks every key-driven transition.
    always_comb begin
        w_state_next    = r_state;
        w_step_cnt_next = r_step_cnt;
        if (w_soft_fire) begin
            w_state_next = ST_IDLE;
        end else if (i_cpu_halt && (r_state != ST_HALT)) begin
            w_state_next = ST_HALT;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_run_go) begin
                        w_state_next = ST_RUN;
                    end else if (w_step_press) begin
                        w_state_next    = ST_STEP;
                        w_step_cnt_next = STEP_LOAD;
                    end
                end
                ST_STEP: begin
                    if (r_step_cnt == 8'd0) begin
                        w_state_next = ST_IDLE;
                    end else begin
                        w_step_cnt_next = r_step_cnt - 8'd1;
                    end
                end
                ST_RUN: begin
                    if (w_run_go) begin
                        w_state_next = ST_IDLE;
                    end
                end
                default: begin
                    w_state_next = r_state;
                end
            endcase
        end
    end

    assign o_cpu_en   = (r_state == ST_STEP) | (r_state == ST_RUN);
    assign o_mode     = r_state;
    assign o_soft_rst = r_soft_rst;

endmodule

// File: tb/tb_run_ctrl.sv
// Directed bench for run_ctrl with a cycle-by-cycle behavioural model checked on every falling edge.
// The model counts remaining enable cycles of a burst rather than mirroring the step counter.
module tb_run_ctrl;

    localparam int LONG = 16;
    localparam int SLEN = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       keyStep = 1'b0;
    logic       keyRun = 1'b0;
    logic       cpuHalt = 1'b0;
    logic       cpuEn;
    logic [1:0] mode;
    logic       softRst;

    int vectors = 0;
    int miscompares = 0;

    int mMode = 0;
    int mHold = 0;
    int mBurst = 0;
    bit mPrevStep = 0;
    bit mPrevRun = 0;
    bit mConsumed = 0;
    bit mSoft = 0;
    bit sp, rr, go, fire;

    int en, pulses, pulseAt;

    run_ctrl #(
        .LONG_CNT (24'(LONG)),
        .STEP_LEN (SLEN)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_key_step (keyStep),
        .i_key_run  (keyRun),
        .i_cpu_halt (cpuHalt),
        .o_cpu_en   (cpuEn),
        .o_mode     (mode),
        .o_soft_rst (softRst)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic r, input logic h);
        keyStep = s;
        keyRun  = r;
        cpuHalt = h;
    endtask

    task automatic cycle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Behavioural model: modes 0 idle, 1 step, 2 run, 3 halt.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mMode = 0; mHold = 0; mBurst = 0;
            mPrevStep = 0; mPrevRun = 0; mConsumed = 0; mSoft = 0;
        end else begin
            sp   = keyStep && !mPrevStep;
            rr   = !keyRun && mPrevRun;
            go   = rr && !mConsumed;
            fire = keyRun && (mHold + 1 == LONG);
            if (fire) mMode = 0;
            else if (cpuHalt && mMode != 3) mMode = 3;
            else begin
                case (mMode)
                    0: if (go) mMode = 2;
                       else if (sp) begin mMode = 1; mBurst = SLEN; end
                    1: begin mBurst--; if (mBurst == 0) mMode = 0; end
                    2: if (go) mMode = 0;
                    default: mMode = 3;
                endcase
            end
            if (fire) mConsumed = 1;
            else if (rr) mConsumed = 0;
            mHold = keyRun ? ((mHold < LONG) ? mHold + 1 : mHold) : 0;
            mSoft = fire;
            mPrevStep = keyStep;
            mPrevRun = keyRun;
        end
    end

    always @(negedge clk) begin
        checkOutput("model_mode", int'(mode), mMode);
        checkOutput("model_cpu_en", int'(cpuEn), (mMode == 1 || mMode == 2) ? 1 : 0);
        checkOutput("model_soft_rst", int'(softRst), int'(mSoft));
    end

    initial begin
        $display("[TB] run_ctrl bench start");
        applyStimulus(0, 0, 0);
        cycle(3);
        checkOutput("reset_mode", int'(mode), 0);
        checkOutput("reset_cpu_en", int'(cpuEn), 0);
        checkOutput("reset_soft_rst", int'(softRst), 0);
        rst = 1'b0;
        cycle(3);
        checkOutput("post_reset_mode", int'(mode), 0);
        checkOutput("post_reset_cpu_en", int'(cpuEn), 0);

        // Step held 5 cycles gives a 3-cycle burst.
        applyStimulus(1, 0, 0);
        en = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(1);
            en += int'(cpuEn);
            if (i == 0) checkOutput("step_mode_start", int'(mode), 1);
            if (i == 3) checkOutput("step_mode_end", int'(mode), 0);
            if (i == 4) applyStimulus(0, 0, 0);
        end
        checkOutput("step_burst_len", en, 3);

        // A second press inside the burst adds nothing.
        applyStimulus(1, 0, 0);
        en = 0;
        cycle(1); en += int'(cpuEn);
        applyStimulus(0, 0, 0);
        cycle(1); en += int'(cpuEn);
        applyStimulus(1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cycle(1); en += int'(cpuEn);
        end
        applyStimulus(0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            cycle(1); en += int'(cpuEn);
        end
        checkOutput("step_repress_len", en, 3);
        checkOutput("step_repress_mode", int'(mode), 0);

        // Run tap, step ignored while running, then pause.
        applyStimulus(0, 1, 0);
        cycle(4);
        checkOutput("run_held_mode", int'(mode), 0);
        applyStimulus(0, 0, 0);
        cycle(1);
        checkOutput("run_mode", int'(mode), 2);
        checkOutput("run_cpu_en", int'(cpuEn), 1);
        applyStimulus(1, 0, 0);
        cycle(2);
        checkOutput("run_step_ignored", int'(mode), 2);
        applyStimulus(0, 0, 0);
        cycle(3);
        checkOutput("run_cpu_en_stays", int'(cpuEn), 1);
        applyStimulus(0, 1, 0);
        cycle(4);
        applyStimulus(0, 0, 0);
        cycle(1);
        checkOutput("pause_mode", int'(mode), 0);
        checkOutput("pause_cpu_en", int'(cpuEn), 0);

        // Halt from run; keys are then ignored.
        applyStimulus(0, 1, 0);
        cycle(2);
        applyStimulus(0, 0, 0);
        cycle(1);
        checkOutput("halt_pre_run", int'(mode), 2);
        applyStimulus(0, 0, 1);
        cycle(1);
        checkOutput("halt_mode", int'(mode), 3);
        checkOutput("halt_cpu_en", int'(cpuEn), 0);
        applyStimulus(1, 0, 0);
        cycle(1);
        applyStimulus(0, 0, 0);
        cycle(1);
        checkOutput("halt_step_ignored", int'(mode), 3);
        applyStimulus(0, 1, 0);
        cycle(3);
        applyStimulus(0, 0, 0);
        cycle(1);
        checkOutput("halt_run_ignored", int'(mode), 3);

        // Long press from halt.
        applyStimulus(0, 1, 0);
        pulses = 0;
        pulseAt = 0;
        for (int i = 1; i <= 20; i++) begin
            cycle(1);
            if (softRst) begin
                pulses++;
                if (pulseAt == 0) pulseAt = i;
            end
            if (i == 16) checkOutput("long_mode_at_pulse", int'(mode), 0);
        end
        checkOutput("long_pulse_count", pulses, 1);
        checkOutput("long_pulse_cycle", pulseAt, LONG);
        applyStimulus(0, 0, 0);
        cycle(1);
        checkOutput("long_release_mode", int'(mode), 0);
        cycle(2);
        checkOutput("long_release_cpu_en", int'(cpuEn), 0);

        // RUN release and STEP press on one edge: run wins.
        applyStimulus(0, 1, 0);
        cycle(3);
        applyStimulus(1, 0, 0);
        cycle(1);
        checkOutput("simul_mode", int'(mode), 2);
        checkOutput("simul_cpu_en", int'(cpuEn), 1);
        cycle(3);
        checkOutput("simul_no_burst", int'(mode), 2);
        applyStimulus(0, 0, 0);
        applyStimulus(0, 1, 0);
        cycle(2);
        applyStimulus(0, 0, 0);
        cycle(1);
        checkOutput("simul_pause", int'(mode), 0);

        // Halt still high across a soft reset re-enters halt next edge.
        applyStimulus(0, 1, 1);
        for (int i = 1; i <= 17; i++) begin
            cycle(1);
            if (i == 1) checkOutput("reentry_halt", int'(mode), 3);
            if (i == 16) begin
                checkOutput("reentry_idle", int'(mode), 0);
                checkOutput("reentry_pulse", int'(softRst), 1);
            end
            if (i == 17) begin
                checkOutput("reentry_halt_again", int'(mode), 3);
                checkOutput("reentry_pulse_done", int'(softRst), 0);
            end
        end
        applyStimulus(0, 0, 0);
        cycle(2);
        checkOutput("reentry_held", int'(mode), 3);
        applyStimulus(0, 1, 0);
        cycle(LONG);
        checkOutput("reentry_exit_mode", int'(mode), 0);
        checkOutput("reentry_exit_pulse", int'(softRst), 1);
        applyStimulus(0, 0, 0);
        cycle(2);
        checkOutput("reentry_exit_idle", int'(mode), 0);

        // Asynchronous reset mid-burst aborts the step.
        applyStimulus(1, 0, 0);
        cycle(1);
        checkOutput("abort_in_step", int'(mode), 1);
        #2;
        rst = 1'b1;
        applyStimulus(0, 0, 0);
        #1;
        checkOutput("abort_async_mode", int'(mode), 0);
        checkOutput("abort_async_cpu_en", int'(cpuEn), 0);
        cycle(1);
        rst = 1'b0;
        cycle(3);
        checkOutput("abort_discarded_mode", int'(mode), 0);
        checkOutput("abort_discarded_cpu_en", int'(cpuEn), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
